// File: rtl/estagio_busca.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps the PC, fetches one word at a time over a req/ack handshake, and presents the
// latched instruction, its opcode field and PC+4 to decode. Taken beq redirects the PC.
// Optional feature: define ESTAGIO_BUSCA_JUMP_EN to add the jmp/jmp_idx redirect inputs.
module estagio_busca #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [15:0]       br_imm,
`ifdef ESTAGIO_BUSCA_JUMP_EN
    input  logic              jmp,
    input  logic [25:0]       jmp_idx,
`endif
    output logic [31:0]       if_instr,
    output logic [5:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc4,
    output logic              if_valid
);

    typedef enum logic [1:0] {StFetch, StWait, StHold, StDiscard} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;

    logic              redirect;
    logic [ADDR_W-1:0] redir_target;
    logic [ADDR_W-1:0] br_target;
    logic              accept;

    // Branch target is relative to PC+4 of the instruction in IF/ID; wrap-around is silent.
    always_comb begin
        br_target = pc4_q + ({{(ADDR_W-16){br_imm[15]}}, br_imm} << 2);
    end

`ifdef ESTAGIO_BUSCA_JUMP_EN
    logic [ADDR_W-1:0] jmp_target;

    // Jump keeps the upper PC+4 bits and replaces the low 28 with the word index; beq wins.
    always_comb begin
        jmp_target       = pc4_q;
        jmp_target[27:0] = {jmp_idx, 2'b00};
        redirect         = br_taken | jmp;
        redir_target     = br_taken ? br_target : jmp_target;
    end
`else
    // Only beq can redirect in this build.
    always_comb begin
        redirect     = br_taken;
        redir_target = br_target;
    end
`endif

    // A returned word is only taken in WAIT and only when no redirect kills it.
    always_comb begin
        accept = (state_q == StWait) && imem_ack && !redirect;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect beats stall.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                state_d = redirect ? StFetch : StWait;
            end
            StWait: begin
                if (redirect) begin
                    // Without an ack the request is still in flight and its ack must be dropped.
                    state_d = imem_ack ? StFetch : StDiscard;
                end else if (imem_ack) begin
                    state_d = stall ? StHold : StFetch;
                end
            end
            StHold: begin
                if (redirect || !stall) begin
                    state_d = StFetch;
                end
            end
            StDiscard: begin
                // A redirect here only moves the PC; the stale ack still has to be swallowed.
                if (imem_ack) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // Output logic; a redirect in FETCH withholds the request so only one is ever outstanding.
    always_comb begin
        imem_req  = (state_q == StFetch) && !redirect && !rst;
        imem_addr = pc_q;
        if_instr  = instr_q;
        if_opcode = instr_q[31:26];
        if_pc4    = pc4_q;
        if_valid  = valid_q;
    end

    // PC and IF/ID next values: change only on redirect or accepted ack.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (redirect) begin
            pc_d    = redir_target;
            instr_d = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            pc_d    = pc_q + ADDR_W'(4);
            instr_d = imem_rdata;
            pc4_d   = pc_q + ADDR_W'(4);
            valid_d = 1'b1;
        end
    end

    // PC and IF/ID registers; low address bits forced to zero so every fetch is word-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= {RESET_PC[ADDR_W-1:2], 2'b00};
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

endmodule
